round_pipe: RTL and testbench
=============================

ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 The block SHALL take parameter MW, default 24, meaning significand width including hidden bit.
REQ-002 The block SHALL take parameter GW, default 3, meaning guard/round/sticky bits below the LSB (GW>=2).
REQ-003 The block SHALL take parameter EW, default 8, meaning biased exponent width.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-005 Upstream ports SHALL be: in_valid input 1; in_ready output 1; in_sign input 1; in_exp input EW; in_sig input MW+GW, normalized (MSB set); in_rm input 3, RISC-V rm encoding.
REQ-006 Downstream ports SHALL be: out_valid output 1; out_ready input 1; out_sign output 1; out_exp output EW; out_sig output MW; out_nx output 1 (inexact); out_of output 1 (overflow); out_rm_inv output 1 (unsupported rm).

Function
REQ-007 Fields SHALL be lsb=in_sig[GW], g=in_sig[GW-1], s=OR of in_sig[GW-2:0], nx=g|s.
REQ-008 Round-up SHALL be: RNE(000) g&(s|lsb); RTZ(001) 0; RDN(010) sign&nx; RUP(011) !sign&nx; RMM(100) g.
REQ-009 rm 101/110/111 SHALL be treated as RNE with out_rm_inv=1.
REQ-010 Stage 1 SHALL register operands plus the round-up decision; stage 2 SHALL add the increment to in_sig[MW+GW-1:GW] in MW+1 bits.
REQ-011 On carry-out, out_sig SHALL be 1 followed by MW-1 zeros and out_exp SHALL be in_exp+1.
REQ-012 If the resulting exponent equals all-ones, out_of=1 and out_nx=1; result SHALL be infinity (exp all-ones, sig all-zero) for RNE/RMM, RUP positive, RDN negative; otherwise max finite (exp all-ones minus 1, sig all-ones).
REQ-013 in_exp all-ones (Inf/NaN) SHALL pass through unchanged with nx=of=0.
REQ-014 Latency SHALL be exactly 2 cycles from accept to out_valid with no stall; throughput one result per cycle.
REQ-015 A transfer SHALL occur when valid and ready are both high on a rising clk edge.
REQ-016 Each stage SHALL advance when the next stage is empty or is transferring in the same cycle; in_ready SHALL equal stage-1-empty OR stage-1-advancing.
REQ-017 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-018 Simultaneous accept and output transfer with both stages full SHALL lose no item and preserve order.
REQ-019 out_valid SHALL never depend combinationally on out_ready; in_ready MAY.

Reset
REQ-020 With rst_n=0 at a clk edge, both stage valids SHALL clear; out_valid=0 and all other outputs 0 the following cycle.
REQ-021 Reset mid-operation SHALL discard in-flight items; in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-022 Macro ROUND_PIPE_DIRECTED_EN SHALL, when defined, enable RDN, RUP and RMM per REQ-008.
REQ-023 Without ROUND_PIPE_DIRECTED_EN, rm 010/011/100 SHALL behave as RNE with out_rm_inv=1; RNE and RTZ unchanged.

Verification
REQ-024 RNE tie: sig 24'h800000 GRS 100 -> 24'h800000, nx=1; sig 24'h800001 GRS 100 -> 24'h800002, nx=1.
REQ-025 Carry: exp 8'h7F, sig 24'hFFFFFF, GRS 110, RNE -> exp 8'h80, sig 24'h800000, nx=1, of=0.
REQ-026 Overflow: exp 8'hFE, sig 24'hFFFFFF, GRS 111 -> RNE: exp 8'hFF sig 0 of=1; RTZ: exp 8'hFE sig 24'hFFFFFF of=1 nx=1.
REQ-027 Backpressure: 4 back-to-back inputs, out_ready low 3 cycles -> in_ready low after 2 accepted, outputs stable, all 4 delivered in order.
REQ-028 Reset with both stages full -> out_valid=0 next cycle, no stale output after release; macro off, rm 011 -> RNE result, out_rm_inv=1.

Source files
------------

// File: rtl/round_pipe_if.sv
// Handshake/bus bundle for round_pipe: upstream operand channel plus downstream result channel.
interface round_pipe_if #(
   parameter int unsigned MW = 24,
   parameter int unsigned GW = 3,
   parameter int unsigned EW = 8
) ();
   logic                in_valid;
   logic                in_ready;
   logic                in_sign;
   logic [EW-1:0]       in_exp;
   logic [MW+GW-1:0]    in_sig;
   logic [2:0]          in_rm;

   logic                out_valid;
   logic                out_ready;
   logic                out_sign;
   logic [EW-1:0]       out_exp;
   logic [MW-1:0]       out_sig;
   logic                out_nx;
   logic                out_of;
   logic                out_rm_inv;

   modport master (
      output in_valid, in_sign, in_exp, in_sig, in_rm, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sig, out_nx, out_of, out_rm_inv
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_sig, in_rm, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sig, out_nx, out_of, out_rm_inv
   );
endinterface

// File: rtl/round_pipe.sv
// Two-stage floating-point significand rounder with valid/ready flow control.
// Define ROUND_PIPE_DIRECTED_EN to enable RDN/RUP/RMM; otherwise they fall back to RNE flagged invalid.
module round_pipe #(
   parameter int unsigned MW = 24,
   parameter int unsigned GW = 3,
   parameter int unsigned EW = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   round_pipe_if.slave bus
);
   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rm_e;

   localparam logic [EW-1:0] EXP_ALL1 = {EW{1'b1}};
   localparam logic [EW-1:0] EXP_TOP  = {{(EW-1){1'b1}}, 1'b0};

   // stage 1: captured operand plus rounding decision
   logic          s1_valid_q, s1_valid_d;
   logic          s1_sign_q, s1_sign_d;
   logic [EW-1:0] s1_exp_q, s1_exp_d;
   logic [MW-1:0] s1_sig_q, s1_sig_d;
   logic          s1_inc_q, s1_inc_d;
   logic          s1_nx_q, s1_nx_d;
   logic          s1_inv_q, s1_inv_d;
   logic          s1_inf_q, s1_inf_d;
   logic          s1_trunc_q, s1_trunc_d;
   logic          s1_special_q, s1_special_d;

   // stage 2: result register driving the outputs
   logic          out_valid_q, out_valid_d;
   logic          out_sign_q, out_sign_d;
   logic [EW-1:0] out_exp_q, out_exp_d;
   logic [MW-1:0] out_sig_q, out_sig_d;
   logic          out_nx_q, out_nx_d;
   logic          out_of_q, out_of_d;
   logic          out_inv_q, out_inv_d;

   rm_e           mode_c;
   logic          rm_inv_c, inc_c, inf_c, lsb_c, g_c, s_c, nx_c, trunc_c, special_c;
   logic [MW-1:0] sig_hi_c;
   logic [MW:0]   sum_c;
   logic [EW-1:0] exp_inc_c;
   logic          s2_free_c, s1_adv_c, in_ready_c, accept_c;

   // rounding-mode decode and round-up decision on the incoming operand
   always_comb begin
      sig_hi_c  = bus.in_sig[MW+GW-1:GW];
      lsb_c     = bus.in_sig[GW];
      g_c       = bus.in_sig[GW-1];
      s_c       = |bus.in_sig[GW-2:0];
      nx_c      = g_c | s_c;
      mode_c    = RM_RNE;
      rm_inv_c  = 1'b0;
      inc_c     = 1'b0;
      inf_c     = 1'b1;
      case (bus.in_rm)
         3'b000:  mode_c = RM_RNE;
         3'b001:  mode_c = RM_RTZ;
`ifdef ROUND_PIPE_DIRECTED_EN
         3'b010:  mode_c = RM_RDN;
         3'b011:  mode_c = RM_RUP;
         3'b100:  mode_c = RM_RMM;
`endif
         default: rm_inv_c = 1'b1;
      endcase
      case (mode_c)
         RM_RNE:  inc_c = g_c & (s_c | lsb_c);
         RM_RTZ:  inf_c = 1'b0;
         RM_RDN:  begin inc_c = bus.in_sign & nx_c;  inf_c = bus.in_sign;  end
         RM_RUP:  begin inc_c = !bus.in_sign & nx_c; inf_c = !bus.in_sign; end
         RM_RMM:  inc_c = g_c;
         default: inc_c = 1'b0;
      endcase
      special_c = (bus.in_exp == EXP_ALL1);
      // largest finite magnitude truncated by a mode that rounds toward zero still overflows
      trunc_c   = nx_c && !inc_c && !inf_c && (bus.in_exp == EXP_TOP) && (&sig_hi_c);
   end

   // pipeline advance: a stage moves when its successor is empty or draining
   always_comb begin
      s2_free_c  = !out_valid_q || bus.out_ready;
      s1_adv_c   = s1_valid_q && s2_free_c;
      in_ready_c = !s1_valid_q || s1_adv_c;
      accept_c   = bus.in_valid && in_ready_c;
      sum_c      = {1'b0, s1_sig_q} + (MW+1)'(s1_inc_q);
      exp_inc_c  = s1_exp_q + EW'(1);
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_sign_d    = s1_sign_q;
      s1_exp_d     = s1_exp_q;
      s1_sig_d     = s1_sig_q;
      s1_inc_d     = s1_inc_q;
      s1_nx_d      = s1_nx_q;
      s1_inv_d     = s1_inv_q;
      s1_inf_d     = s1_inf_q;
      s1_trunc_d   = s1_trunc_q;
      s1_special_d = s1_special_q;
      out_valid_d  = out_valid_q;
      out_sign_d   = out_sign_q;
      out_exp_d    = out_exp_q;
      out_sig_d    = out_sig_q;
      out_nx_d     = out_nx_q;
      out_of_d     = out_of_q;
      out_inv_d    = out_inv_q;

      if (accept_c) begin
         s1_valid_d   = 1'b1;
         s1_sign_d    = bus.in_sign;
         s1_exp_d     = bus.in_exp;
         s1_sig_d     = sig_hi_c;
         s1_inc_d     = inc_c;
         s1_nx_d      = nx_c;
         s1_inv_d     = rm_inv_c;
         s1_inf_d     = inf_c;
         s1_trunc_d   = trunc_c;
         s1_special_d = special_c;
      end else if (s1_adv_c) begin
         s1_valid_d   = 1'b0;
      end

      if (s1_adv_c) begin
         out_valid_d = 1'b1;
         out_sign_d  = s1_sign_q;
         out_inv_d   = s1_inv_q;
         out_exp_d   = s1_exp_q;
         out_sig_d   = sum_c[MW-1:0];
         out_nx_d    = s1_nx_q;
         out_of_d    = 1'b0;
         if (s1_special_q) begin
            out_sig_d = s1_sig_q;
            out_nx_d  = 1'b0;
         end else if (sum_c[MW] && (exp_inc_c == EXP_ALL1)) begin
            out_of_d  = 1'b1;
            out_nx_d  = 1'b1;
            out_exp_d = s1_inf_q ? EXP_ALL1 : EXP_TOP;
            out_sig_d = s1_inf_q ? '0 : '1;
         end else if (sum_c[MW]) begin
            out_exp_d = exp_inc_c;
            out_sig_d = {1'b1, {(MW-1){1'b0}}};
         end else if (s1_trunc_q) begin
            out_of_d  = 1'b1;
            out_nx_d  = 1'b1;
            out_exp_d = EXP_TOP;
            out_sig_d = '1;
         end
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_exp_q     <= '0;
         s1_sig_q     <= '0;
         s1_inc_q     <= 1'b0;
         s1_nx_q      <= 1'b0;
         s1_inv_q     <= 1'b0;
         s1_inf_q     <= 1'b0;
         s1_trunc_q   <= 1'b0;
         s1_special_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_sign_q   <= 1'b0;
         out_exp_q    <= '0;
         out_sig_q    <= '0;
         out_nx_q     <= 1'b0;
         out_of_q     <= 1'b0;
         out_inv_q    <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_sign_q    <= s1_sign_d;
         s1_exp_q     <= s1_exp_d;
         s1_sig_q     <= s1_sig_d;
         s1_inc_q     <= s1_inc_d;
         s1_nx_q      <= s1_nx_d;
         s1_inv_q     <= s1_inv_d;
         s1_inf_q     <= s1_inf_d;
         s1_trunc_q   <= s1_trunc_d;
         s1_special_q <= s1_special_d;
         out_valid_q  <= out_valid_d;
         out_sign_q   <= out_sign_d;
         out_exp_q    <= out_exp_d;
         out_sig_q    <= out_sig_d;
         out_nx_q     <= out_nx_d;
         out_of_q     <= out_of_d;
         out_inv_q    <= out_inv_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_sign   = out_sign_q;
   assign bus.out_exp    = out_exp_q;
   assign bus.out_sig    = out_sig_q;
   assign bus.out_nx     = out_nx_q;
   assign bus.out_of     = out_of_q;
   assign bus.out_rm_inv = out_inv_q;
endmodule

// File: tb/tb_round_pipe.sv
// Bench for round_pipe: vector table through a scoreboard, plus latency, stall and reset sequences.
module tb_round_pipe;
   localparam int unsigned MW = 24;
   localparam int unsigned GW = 3;
   localparam int unsigned EW = 8;
`ifdef ROUND_PIPE_DIRECTED_EN
   localparam bit DIR = 1'b1;
`else
   localparam bit DIR = 1'b0;
`endif
   localparam int NV = 18;

   typedef struct packed {
      logic          sign;
      logic [EW-1:0] exp;
      logic [MW-1:0] sig;
      logic          nx;
      logic          of;
      logic          inv;
   } res_t;

   typedef struct packed {
      logic             sign;
      logic [EW-1:0]    exp;
      logic [MW+GW-1:0] sig;
      logic [2:0]       rm;
      res_t             res;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   round_pipe_if #(.MW(MW), .GW(GW), .EW(EW)) bus ();
   round_pipe #(.MW(MW), .GW(GW), .EW(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   vec_t vecs [NV];
   res_t sb [$];
   res_t drv_exp;
   res_t snap;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_out = 0;
   int   rdy_mode = 0;

   function automatic vec_t mk(input logic sg, input logic [7:0] e, input logic [23:0] m,
                               input logic [2:0] grs, input logic [2:0] rm, input logic rs,
                               input logic [7:0] re, input logic [23:0] rmn,
                               input logic nx, input logic of, input logic inv);
      vec_t v;
      v.sign    = sg;
      v.exp     = e;
      v.sig     = {m, grs};
      v.rm      = rm;
      v.res.sign = rs;
      v.res.exp = re;
      v.res.sig = rmn;
      v.res.nx  = nx;
      v.res.of  = of;
      v.res.inv = inv;
      return v;
   endfunction

   function automatic res_t cur_out();
      res_t r;
      r = {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_nx, bus.out_of, bus.out_rm_inv};
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.in_valid = 1'b1;
      bus.in_sign  = v.sign;
      bus.in_exp   = v.exp;
      bus.in_sig   = v.sig;
      bus.in_rm    = v.rm;
      drv_exp      = v.res;
   endtask

   task automatic send(input vec_t v, input string name);
      logic ok;
      ok = 1'b0;
      drive(v);
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      check({name, " accept"}, 64'(ok), 64'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic set_rdy(input int mode);
      rdy_mode = mode;
      @(posedge clk);
      #2;
   endtask

   initial begin
      vecs[0]  = mk(0, 8'h40, 24'h800000, 3'b100, 3'd0, 0, 8'h40, 24'h800000, 1, 0, 0);
      vecs[1]  = mk(0, 8'h40, 24'h800001, 3'b100, 3'd0, 0, 8'h40, 24'h800002, 1, 0, 0);
      vecs[2]  = mk(0, 8'h7F, 24'hFFFFFF, 3'b110, 3'd0, 0, 8'h80, 24'h800000, 1, 0, 0);
      vecs[3]  = mk(0, 8'hFE, 24'hFFFFFF, 3'b111, 3'd0, 0, 8'hFF, 24'h000000, 1, 1, 0);
      vecs[4]  = mk(0, 8'hFE, 24'hFFFFFF, 3'b111, 3'd1, 0, 8'hFE, 24'hFFFFFF, 1, 1, 0);
      vecs[5]  = mk(0, 8'h10, 24'hC00000, 3'b000, 3'd0, 0, 8'h10, 24'hC00000, 0, 0, 0);
      vecs[6]  = mk(0, 8'h20, 24'h800001, 3'b111, 3'd1, 0, 8'h20, 24'h800001, 1, 0, 0);
      vecs[7]  = mk(0, 8'hFF, 24'h800000, 3'b101, 3'd0, 0, 8'hFF, 24'h800000, 0, 0, 0);
      vecs[8]  = mk(0, 8'h30, 24'h800000, 3'b011, 3'd3, 0, 8'h30,
                    DIR ? 24'h800001 : 24'h800000, 1, 0, !DIR);
      vecs[9]  = mk(0, 8'h30, 24'h800001, 3'b100, 3'd5, 0, 8'h30, 24'h800002, 1, 0, 1);
      vecs[10] = mk(1, 8'h30, 24'hA00000, 3'b110, 3'd2, 1, 8'h30, 24'hA00001, 1, 0, !DIR);
      vecs[11] = mk(0, 8'h30, 24'h800000, 3'b100, 3'd4, 0, 8'h30,
                    DIR ? 24'h800001 : 24'h800000, 1, 0, !DIR);
      vecs[12] = mk(1, 8'h50, 24'h900000, 3'b110, 3'd0, 1, 8'h50, 24'h900001, 1, 0, 0);
      vecs[13] = mk(0, 8'h50, 24'h900000, 3'b011, 3'd0, 0, 8'h50, 24'h900000, 1, 0, 0);
      vecs[14] = mk(1, 8'hFE, 24'hFFFFFF, 3'b111, 3'd2, 1, 8'hFF, 24'h000000, 1, 1, !DIR);
      vecs[15] = mk(1, 8'hFE, 24'hFFFFFF, 3'b111, 3'd3, 1,
                    DIR ? 8'hFE : 8'hFF, DIR ? 24'hFFFFFF : 24'h000000, 1, 1, !DIR);
      vecs[16] = mk(0, 8'hFE, 24'hFFFFFF, 3'b001, 3'd0, 0, 8'hFE, 24'hFFFFFF, 1, 0, 0);
      vecs[17] = mk(0, 8'hFE, 24'hFFFFFF, 3'b000, 3'd1, 0, 8'hFE, 24'hFFFFFF, 0, 0, 0);

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      bus.in_sig    = '0;
      bus.in_rm     = '0;
      bus.out_ready = 1'b1;
      drv_exp       = '0;

      fork
         forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_mode == 0) ? 1'b1 :
                            (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         end
         forever begin
            @(negedge clk);
            if (rst_n) begin
               if (bus.in_valid && bus.in_ready) sb.push_back(drv_exp);
               if (bus.out_valid && bus.out_ready) begin
                  if (sb.size() == 0) begin
                     check($sformatf("out%0d unexpected", n_out), 64'(cur_out()), 64'd0);
                  end else begin
                     check($sformatf("out%0d", n_out), 64'(cur_out()), 64'(sb.pop_front()));
                  end
                  n_out++;
               end
            end
         end
         begin
            #400000;
            $display("FAIL watchdog: got timeout, want finish");
            $fatal(1);
         end
      join_none

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset outputs", 64'(cur_out()), 64'd0);
      rst_n = 1'b1;
      check("reset in_ready", 64'(bus.in_ready), 64'd1);

      // latency: out_valid rises in the second cycle after the accept cycle
      send(vecs[5], "lat");
      bus.in_valid = 1'b0;
      check("lat cycle1 out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat cycle2 out_valid", 64'(bus.out_valid), 64'd1);
      drain();

      // table pass with free-flowing output, then with random backpressure
      for (int pass = 0; pass < 2; pass++) begin
         set_rdy(pass == 0 ? 0 : 2);
         for (int i = 0; i < NV; i++) send(vecs[i], $sformatf("v%0d", i));
         bus.in_valid = 1'b0;
         drain();
      end

      // stall: both stages fill, in_ready drops, held outputs stay stable
      set_rdy(1);
      send(vecs[0], "bp0");
      send(vecs[1], "bp1");
      drive(vecs[2]);
      @(negedge clk);
      check("bp in_ready low", 64'(bus.in_ready), 64'd0);
      check("bp out_valid", 64'(bus.out_valid), 64'd1);
      snap = cur_out();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("bp stable%0d", c), 64'(cur_out()), 64'(snap));
         check($sformatf("bp in_ready%0d", c), 64'(bus.in_ready), 64'd0);
      end
      rdy_mode = 0;
      send(vecs[2], "bp2");
      send(vecs[3], "bp3");
      bus.in_valid = 1'b0;
      drain();

      // reset with both stages full discards everything
      set_rdy(1);
      send(vecs[12], "rs0");
      send(vecs[13], "rs1");
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rs full out_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      check("rs out_valid", 64'(bus.out_valid), 64'd0);
      check("rs outputs", 64'(cur_out()), 64'd0);
      rst_n = 1'b1;
      check("rs in_ready", 64'(bus.in_ready), 64'd1);
      rdy_mode = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("rs stale%0d", c), 64'(bus.out_valid), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
